// File: rtl/vga_timing_ctrl.sv
// VGA scan timing generator: h/v counters, coordinate bus, and a pin stage whose sync and
// blanking are delayed to line up with colour returned by the display logic.
module vga_timing_ctrl #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned PIX_LATENCY = 1
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic [3:0] iRed,
  input  logic [3:0] iGreen,
  input  logic [3:0] iBlue,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic       oActive,
  output logic       oFrame_start,
  output logic [3:0] oVGA_R,
  output logic [3:0] oVGA_G,
  output logic [3:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VLast    = 10'(V_TOTAL - 1);
  // 11-bit bounds so a 1024-count total still compares correctly
  localparam logic [10:0] HActEnd  = 11'(H_VISIBLE);
  localparam logic [10:0] HSyncBeg = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HSyncEnd = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VActEnd  = 11'(V_VISIBLE);
  localparam logic [10:0] VSyncBeg = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VSyncEnd = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  hCnt, vCnt;
  logic [10:0] hCntExt, vCntExt;
  logic        hsRaw, vsRaw;
  logic [2:0]  rawBus, dlyBus;  // {active, hs, vs}
  logic        activeD, hsD, vsD;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hCnt == HLast) begin
      hCnt <= '0;
      vCnt <= (vCnt == VLast) ? '0 : vCnt + 10'd1;
    end else begin
      hCnt <= hCnt + 10'd1;
    end
  end

  assign hCntExt = {1'b0, hCnt};
  assign vCntExt = {1'b0, vCnt};

  assign oActive = (hCntExt < HActEnd) && (vCntExt < VActEnd);
  assign oVGA_X  = oActive ? hCnt : '0;
  assign oVGA_Y  = oActive ? vCnt : '0;

  assign hsRaw  = (hCntExt >= HSyncBeg) && (hCntExt < HSyncEnd);
  assign vsRaw  = (vCntExt >= VSyncBeg) && (vCntExt < VSyncEnd);
  assign rawBus = {oActive, hsRaw, vsRaw};

  // Matches the display logic's colour latency so sync/blank stay aligned with colour.
  generate
    if (PIX_LATENCY == 0) begin : gNoDly
      assign dlyBus = rawBus;
    end else begin : gDly
      logic [2:0] stageQ [PIX_LATENCY];

      always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
          for (int i = 0; i < int'(PIX_LATENCY); i++) stageQ[i] <= '0;
        end else begin
          stageQ[0] <= rawBus;
          for (int i = 1; i < int'(PIX_LATENCY); i++) stageQ[i] <= stageQ[i-1];
        end
      end

      assign dlyBus = stageQ[PIX_LATENCY-1];
    end
  endgenerate

  assign {activeD, hsD, vsD} = dlyBus;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_HS      <= ~SYNC_POL;
      oVGA_VS      <= ~SYNC_POL;
      oFrame_start <= 1'b0;
    end else begin
      oVGA_R       <= activeD ? iRed   : '0;
      oVGA_G       <= activeD ? iGreen : '0;
      oVGA_B       <= activeD ? iBlue  : '0;
      oVGA_HS      <= hsD ^ ~SYNC_POL;
      oVGA_VS      <= vsD ^ ~SYNC_POL;
      oFrame_start <= (hCnt == '0) && (vCnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three default-timing instances (latency 0/1/3) plus a small
// active-high-sync instance that makes full frames affordable to simulate.
module tb_vga_timing_ctrl;

  logic iVGA_CLK;
  logic iRST;
  logic forceF;

  logic [9:0] x   [3];
  logic [9:0] y   [3];
  logic       act [3];
  logic       fs  [3];
  logic       hs  [3];
  logic       vs  [3];
  logic [3:0] r   [3];
  logic [3:0] g   [3];
  logic [3:0] b   [3];
  logic [3:0] red [3];
  logic [3:0] blu [3];
  logic [9:0] hist [3][4];

  logic [9:0] sx, sy;
  logic       sAct, sFs, sHs, sVs;
  logic [3:0] sR, sG, sB;

  int checks = 0;
  int failures = 0;
  int n;
  int errs [4];
  int tIdx;

  typedef struct packed {
    logic       lit;
    logic       hsA;
    logic       vsA;
    logic [3:0] h4;
  } pin_t;

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic [3:0] r;
  } vec_t;

  localparam int NumVec = 16;
  vec_t tbl [NumVec];

  int   falls[$], rises[$], vsOn[$], vsOff[$], fsS[$];
  int   litCnt;
  logic prevHs, prevVs;

  vga_timing_ctrl #(.PIX_LATENCY(0)) dut0 (
    .iVGA_CLK(iVGA_CLK), .iRST(iRST), .iRed(red[0]), .iGreen(red[0]), .iBlue(blu[0]),
    .oVGA_X(x[0]), .oVGA_Y(y[0]), .oActive(act[0]), .oFrame_start(fs[0]),
    .oVGA_R(r[0]), .oVGA_G(g[0]), .oVGA_B(b[0]), .oVGA_HS(hs[0]), .oVGA_VS(vs[0]));

  vga_timing_ctrl #(.PIX_LATENCY(1)) dut1 (
    .iVGA_CLK(iVGA_CLK), .iRST(iRST), .iRed(red[1]), .iGreen(red[1]), .iBlue(blu[1]),
    .oVGA_X(x[1]), .oVGA_Y(y[1]), .oActive(act[1]), .oFrame_start(fs[1]),
    .oVGA_R(r[1]), .oVGA_G(g[1]), .oVGA_B(b[1]), .oVGA_HS(hs[1]), .oVGA_VS(vs[1]));

  vga_timing_ctrl #(.PIX_LATENCY(3)) dut3 (
    .iVGA_CLK(iVGA_CLK), .iRST(iRST), .iRed(red[2]), .iGreen(red[2]), .iBlue(blu[2]),
    .oVGA_X(x[2]), .oVGA_Y(y[2]), .oActive(act[2]), .oFrame_start(fs[2]),
    .oVGA_R(r[2]), .oVGA_G(g[2]), .oVGA_B(b[2]), .oVGA_HS(hs[2]), .oVGA_VS(vs[2]));

  vga_timing_ctrl #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(1'b1), .PIX_LATENCY(2)
  ) dutS (
    .iVGA_CLK(iVGA_CLK), .iRST(iRST), .iRed(4'hF), .iGreen(4'hF), .iBlue(4'hF),
    .oVGA_X(sx), .oVGA_Y(sy), .oActive(sAct), .oFrame_start(sFs),
    .oVGA_R(sR), .oVGA_G(sG), .oVGA_B(sB), .oVGA_HS(sHs), .oVGA_VS(sVs));

  initial iVGA_CLK = 1'b0;
  always #5 iVGA_CLK = ~iVGA_CLK;

  function automatic int latOf(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  // Pin state n clocks after release for a pipeline of lat stages.
  function automatic pin_t pinModel(input int nn, input int hv, input int hf, input int hsw,
                                    input int hb, input int vv, input int vf, input int vsw,
                                    input int vb, input int lat);
    pin_t p;
    int   m, h, v, ht, vt;
    p  = '0;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    m  = nn - lat - 1;
    if (m >= 0) begin
      h     = m % ht;
      v     = (m / ht) % vt;
      p.lit = (h < hv) && (v < vv);
      p.hsA = (h >= hv + hf) && (h < hv + hf + hsw);
      p.vsA = (v >= vv + vf) && (v < vv + vf + vsw);
      p.h4  = 4'(h);
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic driveColour();
    for (int k = 0; k < 3; k++) begin
      red[k] = forceF ? 4'hF : hist[k][latOf(k)][3:0];
      blu[k] = forceF ? 4'hF : ~hist[k][latOf(k)][3:0];
    end
  endtask

  task automatic tick();
    @(posedge iVGA_CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = x[k];
    end
    driveColour();
  endtask

  task automatic releaseRst();
    iRST = 1'b0;
    #1;
    n = 0;
  endtask

  task automatic compareAll();
    pin_t       p;
    logic [3:0] eR, eB, eC;
    int         h, v;
    logic       eAct, eFs;
    for (int k = 0; k < 3; k++) begin
      p    = pinModel(n, 640, 16, 96, 48, 480, 10, 2, 33, latOf(k));
      eR   = p.lit ? p.h4 : 4'h0;
      eB   = p.lit ? ~p.h4 : 4'h0;
      h    = n % 800;
      v    = (n / 800) % 525;
      eAct = (h < 640) && (v < 480);
      eFs  = (n >= 1) && ((n - 1) % 420000 == 0);
      if (r[k] !== eR || g[k] !== eR || b[k] !== eB || hs[k] !== ~p.hsA || vs[k] !== ~p.vsA ||
          act[k] !== eAct || x[k] !== (eAct ? 10'(h) : 10'd0) ||
          y[k] !== (eAct ? 10'(v) : 10'd0) || fs[k] !== eFs)
        errs[k]++;
    end
    p    = pinModel(n, 8, 2, 3, 3, 6, 1, 2, 2, 2);
    eC   = p.lit ? 4'hF : 4'h0;
    h    = n % 16;
    v    = (n / 16) % 11;
    eAct = (h < 8) && (v < 6);
    eFs  = (n >= 1) && ((n - 1) % 176 == 0);
    if (sR !== eC || sG !== eC || sB !== eC || sHs !== p.hsA || sVs !== p.vsA ||
        sAct !== eAct || sx !== (eAct ? 10'(h) : 10'd0) || sy !== (eAct ? 10'(v) : 10'd0) ||
        sFs !== eFs)
      errs[3]++;
  endtask

  task automatic runPhase(input string tag, input int cycles, input bit useTable);
    for (int k = 0; k < 4; k++) errs[k] = 0;
    falls.delete(); rises.delete(); vsOn.delete(); vsOff.delete(); fsS.delete();
    litCnt = 0;
    prevHs = 1'b1;
    prevVs = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      compareAll();
      if (useTable && tIdx < NumVec && tbl[tIdx].n == n) begin
        check($sformatf("%s n=%0d X", tag, n), x[1], tbl[tIdx].x);
        check($sformatf("%s n=%0d Y", tag, n), y[1], tbl[tIdx].y);
        check($sformatf("%s n=%0d active", tag, n), act[1], tbl[tIdx].act);
        check($sformatf("%s n=%0d HS", tag, n), hs[1], tbl[tIdx].hs);
        check($sformatf("%s n=%0d R", tag, n), r[1], tbl[tIdx].r);
        tIdx++;
      end
      if (prevHs && !hs[1]) falls.push_back(n);
      if (!prevHs && hs[1]) rises.push_back(n);
      if (!prevVs && sVs) vsOn.push_back(n);
      if (prevVs && !sVs) vsOff.push_back(n);
      if (sFs) fsS.push_back(n);
      if (n >= 3 && n < 179 && sR == 4'hF) litCnt++;
      prevHs = hs[1];
      prevVs = sVs;
      tick();
      n++;
    end
    check({tag, " model L0"}, errs[0], 0);
    check({tag, " model L1"}, errs[1], 0);
    check({tag, " model L3"}, errs[2], 0);
    check({tag, " model small"}, errs[3], 0);
  endtask

  task automatic checkResetState(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s L%0d RGB", tag, latOf(k)), {r[k], g[k], b[k]}, 0);
      check($sformatf("%s L%0d HS/VS", tag, latOf(k)), {hs[k], vs[k]}, 2'b11);
      check($sformatf("%s L%0d X/Y/act/fs", tag, latOf(k)), {x[k], y[k], act[k], fs[k]},
            {20'd0, 1'b1, 1'b0});
    end
    check({tag, " small RGB"}, {sR, sG, sB}, 0);
    check({tag, " small HS/VS"}, {sHs, sVs}, 2'b00);
  endtask

  initial begin
    tbl[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 4'h0};
    tbl[1]  = '{3,    10'd3,   10'd0, 1'b1, 1'b1, 4'h1};
    tbl[2]  = '{17,   10'd17,  10'd0, 1'b1, 1'b1, 4'hF};
    tbl[3]  = '{18,   10'd18,  10'd0, 1'b1, 1'b1, 4'h0};
    tbl[4]  = '{639,  10'd639, 10'd0, 1'b1, 1'b1, 4'hD};
    tbl[5]  = '{640,  10'd0,   10'd0, 1'b0, 1'b1, 4'hE};
    tbl[6]  = '{641,  10'd0,   10'd0, 1'b0, 1'b1, 4'hF};
    tbl[7]  = '{642,  10'd0,   10'd0, 1'b0, 1'b1, 4'h0};
    tbl[8]  = '{657,  10'd0,   10'd0, 1'b0, 1'b1, 4'h0};
    tbl[9]  = '{658,  10'd0,   10'd0, 1'b0, 1'b0, 4'h0};
    tbl[10] = '{753,  10'd0,   10'd0, 1'b0, 1'b0, 4'h0};
    tbl[11] = '{754,  10'd0,   10'd0, 1'b0, 1'b1, 4'h0};
    tbl[12] = '{800,  10'd0,   10'd1, 1'b1, 1'b1, 4'h0};
    tbl[13] = '{803,  10'd3,   10'd1, 1'b1, 1'b1, 4'h1};
    tbl[14] = '{1457, 10'd0,   10'd0, 1'b0, 1'b1, 4'h0};
    tbl[15] = '{1458, 10'd0,   10'd0, 1'b0, 1'b0, 4'h0};

    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) hist[k][j] = '0;
    iRST   = 1'b1;
    forceF = 1'b0;
    n      = 0;
    tIdx   = 0;
    driveColour();
    repeat (3) tick();
    checkResetState("power-on reset");
    releaseRst();
    runPhase("phaseA", 300, 1'b0);

    // Mid-frame reset with full-scale colour driven in.
    forceF = 1'b1;
    driveColour();
    iRST = 1'b1;
    #1;
    check("async reset clears red", r[1], 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkResetState($sformatf("held reset %0d", i));
    end
    forceF = 1'b0;
    driveColour();
    releaseRst();
    runPhase("phaseB", 1500, 1'b1);

    check("HS fall count", falls.size(), 2);
    check("HS first fall", falls.size() > 0 ? falls[0] : -1, 658);
    check("HS fall period", falls.size() > 1 ? falls[1] - falls[0] : -1, 800);
    check("HS low width", (falls.size() > 0 && rises.size() > 0) ? rises[0] - falls[0] : -1,
          96);
    check("small VS first assert", vsOn.size() > 0 ? vsOn[0] : -1, 115);
    check("small VS width", (vsOn.size() > 0 && vsOff.size() > 0) ? vsOff[0] - vsOn[0] : -1,
          32);
    check("small frame_start first", fsS.size() > 0 ? fsS[0] : -1, 1);
    check("small frame_start period", fsS.size() > 1 ? fsS[1] - fsS[0] : -1, 176);
    check("small lit per frame", litCnt, 48);

    // Reset at h_cnt=700 while pin HS is asserted.
    check("HS asserted before mid-line reset", hs[1], 1'b0);
    iRST = 1'b1;
    #1;
    check("HS released by async reset", hs[1], 1'b1);
    check("small HS released by async reset", sHs, 1'b0);
    repeat (2) tick();
    releaseRst();
    runPhase("phaseC", 900, 1'b0);
    check("HS first fall after mid-line reset", falls.size() > 0 ? falls[0] : -1, 658);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Pixel-clock VGA timing generator and output stage for the game display path. Generates the horizontal/vertical scan counters and drives the pixel coordinate bus consumed by the display/pattern logic. Takes back that logic's RGB a fixed number of clocks later and registers it to the connector pins, with sync and blanking delayed to match. Default timing is 640x480 @ 60 Hz on a 25 MHz pixel clock.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of HS/VS (0 = active-low)
- PIX_LATENCY, 1, clocks from oVGA_X/oVGA_Y change to the matching iRed/iGreen/iBlue; legal range 0..4
- iVGA_CLK  in  1  pixel clock; the only clock
- iRST  in  1  reset, asynchronous, active-high
- iRed / iGreen / iBlue  in  4 each  pixel colour returned by the display logic
- oVGA_X  out  10  current pixel column
- oVGA_Y  out  10  current pixel row
- oActive  out  1  current X/Y lies inside the visible area
- oFrame_start  out  1  one-clock pulse at h_cnt=0, v_cnt=0
- oVGA_R / oVGA_G / oVGA_B  out  4 each  pin colour
- oVGA_HS / oVGA_VS  out  1 each  pin syncs, aligned with pin colour

## Operation
- H_TOTAL = sum of H_* parameters (800); V_TOTAL = sum of V_* parameters (525). Both counters are 10 bits; parameter sets with a total above 1024 are illegal.
- h_cnt increments every clock. It wraps from H_TOTAL-1 to 0.
- v_cnt increments only on the clock where h_cnt wraps. It wraps from V_TOTAL-1 to 0 on the same clock that h_cnt wraps at the end of line V_TOTAL-1.
- oActive = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE). This output is combinational from the counter registers.
- oVGA_X = h_cnt and oVGA_Y = v_cnt while oActive is high; both are 0 while oActive is low.
- Internal hs_raw is active while H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC, i.e. counts 656..751 by default.
- Internal vs_raw is active while V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491. It is a whole-line signal and changes on h_cnt wrap.
- Alignment: hs_raw, vs_raw and oActive enter a shift register PIX_LATENCY stages deep. With PIX_LATENCY=0 the stage is a wire.
- Output register, one stage, every clock:
  - oVGA_R/G/B <= active_d ? iRed/iGreen/iBlue : 0.
  - oVGA_HS <= hs_d ^ ~SYNC_POL, and oVGA_VS <= vs_d ^ ~SYNC_POL. Asserted sync therefore equals SYNC_POL.
- oFrame_start is registered. It is high for exactly one clock, the clock after the counters reach (0,0).
- Reset values (held while iRST is high):
  - h_cnt = 0, v_cnt = 0.
  - All delay stages hold the inactive value (not active, syncs deasserted).
  - oVGA_R/G/B = 0, oVGA_HS = oVGA_VS = ~SYNC_POL, oFrame_start = 0.
  - oVGA_X/Y follow the counters, so they read 0 and oActive reads 1.
- Reset asserted mid-frame clears everything above immediately (asynchronously). After release, scanning restarts at (0,0) and no partial sync pulse is emitted. Colour stays blanked until the delay line carries active data.

## Timing
- Coordinate-to-pin latency is PIX_LATENCY+1 clocks. Colour for the pixel at (X,Y) appears on pins PIX_LATENCY+1 clocks after X/Y are presented. HS, VS and blanking for that pixel appear on the same clock.
- First clock after reset release: counter = (0,0). The first visible colour reaches the pins PIX_LATENCY+1 clocks later.
- HS period is 800 clocks, asserted 96. VS period is 420000 clocks, asserted 1600 (two full lines).
- Frame rate is iVGA_CLK / 420000, about 59.5 Hz at 25 MHz.
- oFrame_start recurs every H_TOTAL*V_TOTAL clocks.
- No handshake. The display logic must return colour with exactly PIX_LATENCY clocks of delay; any other delay shifts the image horizontally.

## Test plan
- Reset: hold iRST for 5 clocks in mid-frame, driving iRed=F. Required: pins R/G/B=0 and HS=VS=1 (SYNC_POL=0) while reset is held. After release, oVGA_X=0, oVGA_Y=0, oActive=1.
- Horizontal timing, default parameters, PIX_LATENCY=1: oVGA_HS falls 658 clocks after reset release and stays low exactly 96 clocks. Falling edges are 800 clocks apart. oVGA_X rolls from 639 to 0 (blanked) at count 640.
- Vertical timing: oVGA_VS low for exactly 1600 clocks, starting 490*800+2 clocks after release. oFrame_start pulses are 420000 clocks apart.
- Latency/alignment: a model drives iRed = X[3:0] delayed PIX_LATENCY clocks, for PIX_LATENCY = 0, 1 and 3. Required: the pin red pattern is 0,1,2,…,F repeating from the first active pin pixel. Pin red is 0 for all 160 blank clocks of every line.
- Blanking: iRed/iGreen/iBlue forced to F/F/F constantly. Required: pins are F only on the 640x480 active window; the pin count is exactly 307200 lit clocks per frame.
- Reset mid-line at h_cnt=700 (during HS): HS returns high immediately on iRST. No short HS pulse appears after release; the next HS fall occurs 658 clocks after release.
